// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Serializes press / auto-repeat / release events from NUM_BTNS debounced
// button levels onto one valid/ready event port, round-robin across buttons.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_btn[NUM_BTNS]       debounced button levels (1 = pressed), synchronous
//   o_evt_valid/i_evt_ready  event handshake
//   o_evt_id[ID_W]        button index of the presented event
//   o_evt_kind[2]         0 = press, 1 = repeat, 2 = release
//   o_drop                one-cycle pulse when a press/release was lost
//
// Build option: define BTN_AUTOREPEAT_EN to build the hold timers and repeat
// events; otherwise only press and release events exist.
module button_event_arbiter #(
    parameter int unsigned NUM_BTNS      = 4,
    parameter int unsigned ID_W          = 2,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned HOLD_CYCLES   = 12000000,
    parameter int unsigned REPEAT_CYCLES = 3000000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_BTNS-1:0] i_btn,
    output logic                o_evt_valid,
    input  logic                i_evt_ready,
    output logic [ID_W-1:0]     o_evt_id,
    output logic [1:0]          o_evt_kind,
    output logic                o_drop
);

    localparam int unsigned IDX_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    localparam logic [1:0] KIND_PRESS   = 2'd0;
    localparam logic [1:0] KIND_RELEASE = 2'd2;

    // Elaboration-time parameter legality checks
    if (NUM_BTNS < 2 || NUM_BTNS > 16) begin : g_bad_num_btns
        $error("button_event_arbiter: NUM_BTNS must be 2..16");
    end
    if ((64'd1 << ID_W) < 64'(NUM_BTNS)) begin : g_bad_id_w
        $error("button_event_arbiter: ID_W too narrow for NUM_BTNS");
    end
    if (CNT_W < 2 || CNT_W > 32 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        64'(HOLD_CYCLES) >= (64'd1 << CNT_W) ||
        64'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_timer
        $error("button_event_arbiter: hold/repeat counts do not fit CNT_W");
    end

    logic [NUM_BTNS-1:0] prev_q, prev_d;
    logic [NUM_BTNS-1:0] pend_press_q, pend_press_d;
    logic [NUM_BTNS-1:0] pend_rel_q, pend_rel_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]     evt_id_q, evt_id_d;
    logic [1:0]          evt_kind_q, evt_kind_d;
    logic                drop_q, drop_d;

    logic [NUM_BTNS-1:0] press_edge_c, rel_edge_c, any_pend_c;
    logic [NUM_BTNS-1:0] gnt_onehot_c, gnt_press_c, gnt_rel_c;
    logic                slot_free_c, found_c;
    logic [IDX_W-1:0]    gnt_idx_c;
    logic [1:0]          gnt_kind_c;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [1:0]       KIND_REPEAT = 2'd1;
    localparam logic [CNT_W-1:0] HOLD_LIM    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LIM     = CNT_W'(REPEAT_CYCLES - 1);

    logic [NUM_BTNS-1:0][CNT_W-1:0] timer_q, timer_d;
    logic [NUM_BTNS-1:0]            rep_phase_q, rep_phase_d;
    logic [NUM_BTNS-1:0]            pend_rep_q, pend_rep_d;
    logic [NUM_BTNS-1:0]            rep_fire_c, gnt_rep_c;

    assign any_pend_c = pend_press_q | pend_rep_q | pend_rel_q;
    assign gnt_rep_c  = (gnt_kind_c == KIND_REPEAT) ? gnt_onehot_c : '0;

    // Hold timers: only run while the button stays held, so the release
    // edge itself can never fire a repeat.
    always_comb begin
        timer_d     = timer_q;
        rep_phase_d = rep_phase_q;
        rep_fire_c  = '0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            if (!(prev_q[i] && i_btn[i])) begin
                timer_d[i]     = '0;
                rep_phase_d[i] = 1'b0;
            end else if (timer_q[i] == (rep_phase_q[i] ? REP_LIM : HOLD_LIM)) begin
                timer_d[i]     = '0;
                rep_fire_c[i]  = 1'b1;
                rep_phase_d[i] = 1'b1;
            end else begin
                timer_d[i] = timer_q[i] + CNT_W'(1);
            end
        end
        // Repeats coalesce silently; a new firing wins over a same-cycle grant
        pend_rep_d = (pend_rep_q & ~gnt_rep_c) | rep_fire_c;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q     <= '0;
            rep_phase_q <= '0;
            pend_rep_q  <= '0;
        end else begin
            timer_q     <= timer_d;
            rep_phase_q <= rep_phase_d;
            pend_rep_q  <= pend_rep_d;
        end
    end
`else
    assign any_pend_c = pend_press_q | pend_rel_q;
`endif

    assign press_edge_c = i_btn & ~prev_q;
    assign rel_edge_c   = ~i_btn & prev_q;
    assign slot_free_c  = !evt_valid_q || i_evt_ready;

    // Round-robin search starting after the last granted button
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [IDX_W-1:0] idx;
        found_c    = 1'b0;
        gnt_idx_c  = '0;
        gnt_kind_c = KIND_PRESS;
        for (int unsigned k = 1; k <= NUM_BTNS; k++) begin
            sum = SUM_W'(last_q) + SUM_W'(k);
            if (sum >= SUM_W'(NUM_BTNS)) begin
                sum = sum - SUM_W'(NUM_BTNS);
            end
            idx = IDX_W'(sum);
            if (!found_c && any_pend_c[idx]) begin
                found_c   = 1'b1;
                gnt_idx_c = idx;
                if (pend_press_q[idx]) begin
                    gnt_kind_c = KIND_PRESS;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (pend_rep_q[idx]) begin
                    gnt_kind_c = KIND_REPEAT;
                end
`endif
                else begin
                    gnt_kind_c = KIND_RELEASE;
                end
            end
        end
    end

    // One-hot clear mask for the pending bit consumed by this cycle's load
    always_comb begin
        gnt_onehot_c = '0;
        if (slot_free_c && found_c) begin
            gnt_onehot_c[gnt_idx_c] = 1'b1;
        end
        gnt_press_c = (gnt_kind_c == KIND_PRESS)   ? gnt_onehot_c : '0;
        gnt_rel_c   = (gnt_kind_c == KIND_RELEASE) ? gnt_onehot_c : '0;
    end

    // Pending bits, drop detection and the output slot
    always_comb begin
        prev_d       = i_btn;
        pend_press_d = (pend_press_q & ~gnt_press_c) | press_edge_c;
        pend_rel_d   = (pend_rel_q & ~gnt_rel_c) | rel_edge_c;
        // A bit being granted this cycle is not lost when re-set
        drop_d       = (|(press_edge_c & pend_press_q & ~gnt_press_c)) |
                       (|(rel_edge_c & pend_rel_q & ~gnt_rel_c));
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        evt_kind_d   = evt_kind_q;
        last_d       = last_q;
        if (slot_free_c) begin
            evt_valid_d = found_c;
            if (found_c) begin
                evt_id_d   = ID_W'(gnt_idx_c);
                evt_kind_d = gnt_kind_c;
                last_d     = gnt_idx_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q       <= '0;
            pend_press_q <= '0;
            pend_rel_q   <= '0;
            last_q       <= IDX_W'(NUM_BTNS - 1);
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_kind_q   <= KIND_PRESS;
            drop_q       <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
            last_q       <= last_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_kind_q   <= evt_kind_d;
            drop_q       <= drop_d;
        end
    end

    assign o_evt_valid = evt_valid_q;
    assign o_evt_id    = evt_id_q;
    assign o_evt_kind  = evt_kind_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed testbench for button_event_arbiter (HOLD_CYCLES=20, REPEAT_CYCLES=5).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_button_event_arbiter;

    localparam int unsigned NUM_BTNS = 4;
    localparam int unsigned ID_W     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_BTNS-1:0] btn = '0;
    logic                ready = 1'b0;
    logic                valid;
    logic [ID_W-1:0]     id;
    logic [1:0]          kind;
    logic                drop;
    logic [4:0]          obs;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [3:0] acc_evt[$];
    int         acc_cyc[$];

    button_event_arbiter #(
        .NUM_BTNS     (NUM_BTNS),
        .ID_W         (ID_W),
        .CNT_W        (8),
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(5)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn      (btn),
        .o_evt_valid(valid),
        .i_evt_ready(ready),
        .o_evt_id   (id),
        .o_evt_kind (kind),
        .o_drop     (drop)
    );

    always #5 clk = ~clk;

    assign obs = {valid, id, kind};

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted event ({id, kind}) with the cycle it was accepted in
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            acc_evt.push_back({id, kind});
            acc_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = '0;
        ready = 1'b0;
        tick(3);
        checks++;
        if (obs !== 5'b0_00_00) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 5'b0_00_00);
        end
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop: got %b expected 0", drop);
        end
        rst_n = 1'b1;
        ready = 1'b1;
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got valid=%b expected 0", valid);
        end
    endtask

    task automatic test_round_robin;
        btn = 4'b1011;
        tick(2);
        checks++;
        if (obs !== 5'b1_00_00) begin
            failures++;
            $display("FAIL rr_first: got %b expected %b", obs, 5'b1_00_00);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_01_00) begin
            failures++;
            $display("FAIL rr_second: got %b expected %b", obs, 5'b1_01_00);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_11_00) begin
            failures++;
            $display("FAIL rr_third: got %b expected %b", obs, 5'b1_11_00);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle: got valid=%b expected 0", valid);
        end
        btn = 4'b0000;
        tick(2);
        checks++;
        if (obs !== 5'b1_00_10) begin
            failures++;
            $display("FAIL rr_rel0: got %b expected %b", obs, 5'b1_00_10);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_01_10) begin
            failures++;
            $display("FAIL rr_rel1: got %b expected %b", obs, 5'b1_01_10);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_11_10) begin
            failures++;
            $display("FAIL rr_rel3: got %b expected %b", obs, 5'b1_11_10);
        end
        tick(2);
        // last is now 3: a burst on 0 and 1 must come out 0 then 1
        btn = 4'b0011;
        tick(2);
        checks++;
        if (obs !== 5'b1_00_00) begin
            failures++;
            $display("FAIL rr2_first: got %b expected %b", obs, 5'b1_00_00);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_01_00) begin
            failures++;
            $display("FAIL rr2_second: got %b expected %b", obs, 5'b1_01_00);
        end
        btn = 4'b0000;
        tick(6);
    endtask

    task automatic test_single_press;
        acc_evt.delete();
        acc_cyc.delete();
        btn = 4'b0100;
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency1: got valid=%b expected 0", valid);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_10_00) begin
            failures++;
            $display("FAIL single_latency2: got %b expected %b", obs, 5'b1_10_00);
        end
        tick(8);
        btn = 4'b0000;
        tick(6);
        checks++;
        if (acc_evt.size() != 2) begin
            failures++;
            $display("FAIL single_count: got %0d events expected 2", acc_evt.size());
        end else begin
            checks++;
            if (acc_evt[0] !== 4'b10_00) begin
                failures++;
                $display("FAIL single_ev0: got %b expected %b", acc_evt[0], 4'b10_00);
            end
            checks++;
            if (acc_evt[1] !== 4'b10_10) begin
                failures++;
                $display("FAIL single_ev1: got %b expected %b", acc_evt[1], 4'b10_10);
            end
        end
    endtask

    task automatic test_autorepeat;
        logic [3:0] exp_evt[$];
        acc_evt.delete();
        acc_cyc.delete();
        exp_evt.push_back(4'b01_00);
`ifdef BTN_AUTOREPEAT_EN
        repeat (4) exp_evt.push_back(4'b01_01);
`endif
        exp_evt.push_back(4'b01_10);
        btn = 4'b0010;
        tick(40);
        btn = 4'b0000;
        tick(8);
        checks++;
        if (acc_evt.size() != exp_evt.size()) begin
            failures++;
            $display("FAIL ar_count: got %0d events expected %0d", acc_evt.size(), exp_evt.size());
        end else begin
            for (int i = 0; i < exp_evt.size(); i++) begin
                checks++;
                if (acc_evt[i] !== exp_evt[i]) begin
                    failures++;
                    $display("FAIL ar_ev%0d: got %b expected %b", i, acc_evt[i], exp_evt[i]);
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 20) begin
                failures++;
                $display("FAIL ar_hold_gap: got %0d cycles expected 20", acc_cyc[1] - acc_cyc[0]);
            end
            for (int i = 2; i < 5; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 5) begin
                    failures++;
                    $display("FAIL ar_rep_gap%0d: got %0d cycles expected 5", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
`endif
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat[15];
        int drops;
        int drop_at;
        pat = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        drops   = 0;
        drop_at = -1;
        ready   = 1'b0;
        btn     = 4'b0010;
        tick(2);
        checks++;
        if (obs !== 5'b1_01_00) begin
            failures++;
            $display("FAIL bp_load: got %b expected %b", obs, 5'b1_01_00);
        end
        for (int i = 0; i < 15; i++) begin
            btn = pat[i];
            tick(1);
            if (drop === 1'b1) begin
                drops++;
                drop_at = i;
            end
            checks++;
            if (obs !== 5'b1_01_00) begin
                failures++;
                $display("FAIL bp_hold%0d: got %b expected %b", i, obs, 5'b1_01_00);
            end
        end
        checks++;
        if (drop_at != 6) begin
            failures++;
            $display("FAIL bp_drop_cycle: got %0d expected 6", drop_at);
        end
        ready = 1'b1;
        tick(1);
        checks++;
        if (obs !== 5'b1_00_00) begin
            failures++;
            $display("FAIL bp_drain0: got %b expected %b", obs, 5'b1_00_00);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_01_10) begin
            failures++;
            $display("FAIL bp_drain1: got %b expected %b", obs, 5'b1_01_10);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_00_10) begin
            failures++;
            $display("FAIL bp_drain2: got %b expected %b", obs, 5'b1_00_10);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: got valid=%b expected 0", valid);
        end
        btn = 4'b0000;
        tick(2);
        checks++;
        if (obs !== 5'b1_00_10) begin
            failures++;
            $display("FAIL bp_final_rel: got %b expected %b", obs, 5'b1_00_10);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (drop === 1'b1) drops++;
        end
        checks++;
        if (drops != 1) begin
            failures++;
            $display("FAIL bp_drop_count: got %0d expected 1", drops);
        end
    endtask

    task automatic test_reset_mid;
        ready = 1'b0;
        btn   = 4'b1000;
        tick(2);
        checks++;
        if (obs !== 5'b1_11_00) begin
            failures++;
            $display("FAIL rm_load: got %b expected %b", obs, 5'b1_11_00);
        end
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs, drop} !== 6'b0_00_00_0) begin
            failures++;
            $display("FAIL rm_async: got %b expected %b", {obs, drop}, 6'b0_00_00_0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_latency1: got valid=%b expected 0", valid);
        end
        tick(1);
        checks++;
        if (obs !== 5'b1_11_00) begin
            failures++;
            $display("FAIL rm_first_evt: got %b expected %b", obs, 5'b1_11_00);
        end
        ready = 1'b1;
        btn   = 4'b0000;
        tick(5);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_drained: got valid=%b expected 0", valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_press();
        test_autorepeat();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Turns the debounced level outputs of up to `NUM_BTNS` debouncers into a single serialized stream of button events: press, auto-repeat and release. Each button raises its own pending events. The block arbitrates among buttons round-robin and presents one event at a time on a valid/ready port. It sits between the per-button debouncers and the LCD menu/control logic.

## Interface
- `NUM_BTNS`, 4: number of button inputs, 2..16.
- `ID_W`, 2: width of the event id; must satisfy 2^ID_W ≥ NUM_BTNS.
- `CNT_W`, 24: width of the per-button hold timer.
- `HOLD_CYCLES`, 12000000: cycles a button must be held before the first repeat event; 2 ≤ value < 2^CNT_W.
- `REPEAT_CYCLES`, 3000000: cycles between subsequent repeat events; 2 ≤ value < 2^CNT_W.
- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_btn`  in  NUM_BTNS  debounced button levels, already synchronous to `i_clk`; 1 = pressed.
- `o_evt_valid`  out  1  an event is presented.
- `i_evt_ready`  in  1  the consumer accepts the event.
- `o_evt_id`  out  ID_W  index of the button that produced the event.
- `o_evt_kind`  out  2  event kind: 0 = press, 1 = repeat, 2 = release; 3 is never produced.
- `o_drop`  out  1  one-cycle pulse when an event was lost because its pending bit was already set.

## Operation
- **Edge detection.** Each button keeps a registered copy `prev` of its level.
  - Press: `i_btn[i]` = 1 while `prev[i]` = 0.
  - Release: `i_btn[i]` = 0 while `prev[i]` = 1.
- **Pending state.** Each button holds three pending bits: `pend_press`, `pend_rep`, `pend_rel`.
  - An edge sets its bit on the same clock edge that updates `prev`.
  - Press while `pend_press` is already set: event dropped, `o_drop` pulses. Release behaves the same with `pend_rel`.
  - Repeat while `pend_rep` is already set: the two repeats coalesce silently, with no `o_drop`.
- **Hold timer (per button).**
  - Cleared whenever `prev[i]` = 0.
  - While `prev[i]` = 1 it increments each cycle.
  - At `HOLD_CYCLES`-1 on the first firing, or at `REPEAT_CYCLES`-1 on later firings, it sets `pend_rep`, returns to 0 and sets the button's repeat-phase flag.
  - The repeat-phase flag is cleared on release.
- **Arbitration.** The output slot loads when the slot is free, i.e. `!o_evt_valid || i_evt_ready`, and at least one pending bit is set.
  - Search order starts at button `last+1` and wraps modulo `NUM_BTNS`.
  - Within one button the priority is press > repeat > release.
  - On load: `o_evt_id` and `o_evt_kind` are registered, `o_evt_valid` goes to 1, the granted pending bit clears, and `last` takes the granted id.
- **Simultaneous events.** If a pending bit is cleared by a grant and set by a new event on the same cycle, the set wins.
- **Output hold.** While `o_evt_valid` = 1 and `i_evt_ready` = 0, `o_evt_valid`, `o_evt_id` and `o_evt_kind` hold stable.
- **Idle.** With no pending events and the current event accepted, `o_evt_valid` drops to 0 on the next edge.

## Timing
- **Reset values.** `o_evt_valid` = 0, `o_evt_id` = 0, `o_evt_kind` = 0, `o_drop` = 0.
  - All `prev`, pending bits, timers and repeat-phase flags = 0; `last` = NUM_BTNS-1, so the first search starts at button 0.
- **Button held through reset.** The first edge after reset deassertion sees a press; this is required behaviour.
- **Reset mid-operation.** Asserting reset discards all pending events and the presented event immediately.
- **Latency.** `i_btn[i]` is first high before edge k. The pending bit sets at edge k. With the slot free, `o_evt_valid` is 1 after edge k+1, giving 2 cycles from input to output.
- **Throughput.** One event per cycle while `i_evt_ready` = 1, because a load may coincide with an accept.
- **Repeat timing.** From the press edge, the first repeat becomes pending after `HOLD_CYCLES` cycles. Each later repeat follows every `REPEAT_CYCLES` cycles.
- **o_drop.** Registered; it is high for the one cycle after the edge that lost the event.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: hold timers, repeat-phase flags and repeat events are present as described above.
- `BTN_AUTOREPEAT_EN` undefined:
  - Timers, repeat-phase flags and `pend_rep` are not built.
  - `o_evt_kind` only takes the values 0 and 2.
  - `HOLD_CYCLES`, `REPEAT_CYCLES` and `CNT_W` are ignored.

## Test plan
- **Single press/release.** Bench parameters `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5. Button 2 pulses high for 10 cycles with `i_evt_ready` = 1 → exactly {id 2, kind 0} and then {id 2, kind 2}. `o_evt_valid` first rises 2 cycles after the rising input.
- **Auto-repeat.** Button 1 held for 40 cycles, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5 → press, repeats at cycles 20, 25, 30, 35, then release. With the macro undefined: press and release only.
- **Round-robin.** Buttons 0, 1 and 3 rise on the same cycle → press events in id order 0, 1, 3 on consecutive cycles.
  - A second simultaneous burst on buttons 0 and 1 while `last` = 3 yields id order 0, 1.
- **Backpressure.** `i_evt_ready` = 0 for 15 cycles with a press pending → `o_evt_valid`/`o_evt_id`/`o_evt_kind` stay stable. Button 0 press, release and press again during the stall → `o_drop` pulses once, for the second press. After ready: press, then release.
- **Reset.** `i_rst_n` pulsed low mid-stall while button 3 is held → outputs immediately 0. After deassertion, the first event is {id 3, kind 0}.
